// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub wrap modulo 2^ALU_WIDTH, and/or bitwise.
module alu
  import alu_pkg::*;
#(
  parameter int ALU_WIDTH = 16
) (
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  op_e                  op,
  output logic [ALU_WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter for two requesters sharing one ALU, with a single-entry
// response register that sustains one op per cycle when the consumer is ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ALU_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][ALU_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][ALU_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0][1:0]             req_opcode,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [ALU_WIDTH-1:0]                rsp_data,
  output logic                                rsp_id
);
  state_e               state;
  logic                 ptr;
  logic                 win;
  logic                 can_accept;
  logic                 accept;
  logic [ALU_WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [1:0]           alu_op;

  // Winner depends only on valids and ptr, never on operand data.
  always_comb begin
    win = 1'b0;
    if (req_valid == 2'b11) win = ptr;
    else if (req_valid[1])  win = 1'b1;
  end

  assign can_accept = (state == EMPTY) || rsp_ready;

  always_comb begin
    req_ready = '0;
    if (rst_n && can_accept && req_valid[win]) req_ready[win] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  assign alu_a  = req_a[win];
  assign alu_b  = req_b[win];
  assign alu_op = req_opcode[win];

  alu #(.ALU_WIDTH(ALU_WIDTH)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (op_e'(alu_op)),
    .y  (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      ptr      <= 1'b0;
    end else if (accept) begin
      state    <= FULL;
      rsp_data <= alu_y;
      rsp_id   <= win;
      ptr      <= ~win;
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);
endmodule
